btn_ctrl: RTL
=============

BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, MMIO word address width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000, consecutive stable cycles required to accept a level change; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 btn1, btn2  input  1 each  raw button pins; active-low (0 = pressed); asynchronous to clk.
REQ-006 read_enable  input  1  MMIO read strobe, one cycle per access.
REQ-007 write_enable  input  1  MMIO write strobe, one cycle per access.
REQ-008 address  input  ADDR_WIDTH  register word address.
REQ-009 data_in  input  32  write data.
REQ-010 data_out  output  32  registered read data.
REQ-011 irq  output  1  level interrupt request, registered.

Function
REQ-012 Each pin SHALL pass a 2-flop synchronizer; the debouncer sees only the synchronized value.
REQ-013 Each debouncer SHALL have states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 RELEASED -> PRESS_WAIT when sync = pressed; counter = 0.
REQ-015 PRESS_WAIT: sync pressed -> counter +1; when counter = DEBOUNCE_CYCLES-1 and sync pressed -> PRESSED; sync released at any point -> RELEASED, counter = 0.
REQ-016 PRESSED -> RELEASE_WAIT -> RELEASED follows the same rules with polarity inverted.
REQ-017 The RELEASED->...->PRESSED entry edge SHALL produce a one-cycle press event; release produces no event.
REQ-018 Register map (word addresses): 0 STATUS, 1 LEVEL, 2 CTRL, 3 COUNT1, 4 COUNT2; all other addresses read 0 and ignore writes.
REQ-019 STATUS bits[1:0] = sticky press events for btn2, btn1; set on the press-event edge; bits[31:2] = 0.
REQ-020 LEVEL bits[1:0] = 1 when the debouncer is in PRESSED or RELEASE_WAIT.
REQ-021 CTRL bits[1:0] = irq enables for btn2, btn1; read/write; bits[31:2] read 0.
REQ-022 COUNT1/COUNT2 = 16-bit press counters in bits[15:0]; +1 per press event; wrap 0xFFFF -> 0x0000; any write clears to 0.
REQ-023 Read: data_out SHALL present register value on the edge after read_enable (1-cycle latency); data_out = 0 on every cycle without a read.
REQ-024 STATUS read SHALL return the pre-clear value and clear all bits on the same edge.
REQ-025 STATUS write SHALL be write-1-to-clear per bit.
REQ-026 A press event coinciding with a STATUS clear (read or W1C) SHALL leave that bit set; set wins over clear.
REQ-027 A press event coinciding with a COUNT write SHALL yield count = 1.
REQ-028 read_enable and write_enable both high: perform write only; data_out = 0.
REQ-029 irq SHALL equal registered OR of (STATUS & CTRL[1:0]); asserts the cycle after the causing bit becomes set, deasserts the cycle after clearing.
REQ-030 Both buttons SHALL be fully independent; simultaneous events on both set both bits.

Reset
REQ-031 rst_n = 0 at a posedge: synchronizers to released (1), debouncers RELEASED, counters 0, STATUS 0, CTRL 0, COUNT1/COUNT2 0, data_out 0, irq 0.
REQ-032 Reset mid-debounce or mid-access SHALL discard the pending event/read; a button held through reset deassertion is re-debounced from RELEASED.

Structure
REQ-033 Shared package btn_ctrl_pkg SHALL hold register address constants, debouncer state typedef, counter width constant.
REQ-034 One sub-module btn_debounce (synchronizer + state machine + event pulse), instantiated twice.

Verification (DEBOUNCE_CYCLES = 4)
REQ-035 btn1 driven 0 at edge 0, held -> STATUS bit0 set and COUNT1 = 1 at edge 7; LEVEL = 0x1.
REQ-036 btn1 low 3 cycles, high 1, low 3 (bounce) -> no event, COUNT1 = 0, STATUS = 0.
REQ-037 CTRL = 0x3, btn2 press -> irq = 1 one cycle after STATUS bit1 sets; read STATUS -> data_out = 0x2, next read 0x0, irq drops.
REQ-038 STATUS read on exact press-event edge of btn1 -> data_out = 0x0, STATUS bit0 remains 1.
REQ-039 COUNT1 preset by 65535 presses, one more press -> COUNT1 = 0x0000.
REQ-040 rst_n = 0 during PRESS_WAIT with btn1 held -> all outputs 0; after release of rst_n, event at edge 7 relative to reset deassertion.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// rtl/btn_ctrl_pkg.sv - shared constants and types for the button controller
package btn_ctrl_pkg;

    localparam int CNT_W = 16;

    localparam int ADDR_STATUS = 0;
    localparam int ADDR_LEVEL  = 1;
    localparam int ADDR_CTRL   = 2;
    localparam int ADDR_COUNT1 = 3;
    localparam int ADDR_COUNT2 = 4;

    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_PRESS_WAIT,
        DB_PRESSED,
        DB_RELEASE_WAIT
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, debounce state machine and press pulse for one active-low pin
module btn_debounce
    import btn_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= DB_RELEASED;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            case (r_state)
                DB_RELEASED: begin
                    if (!r_sync2) begin
                        r_state <= DB_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (r_sync2) begin
                        r_state <= DB_RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= DB_PRESSED;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DB_PRESSED: begin
                    if (r_sync2) begin
                        r_state <= DB_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                DB_RELEASE_WAIT: begin
                    if (!r_sync2) begin
                        r_state <= DB_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= DB_RELEASED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= DB_RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level = (r_state == DB_PRESSED) || (r_state == DB_RELEASE_WAIT);
    assign o_press = r_press;

endmodule

// File: rtl/btn_ctrl.sv
// rtl/btn_ctrl.sv - two-button debounced controller with MMIO status, counters and interrupt
module btn_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn1,
    input  logic                  btn2,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  irq
);

    logic [1:0]       w_press;
    logic [1:0]       w_level;
    logic             w_rd;
    logic             w_sel_status;
    logic             w_sel_ctrl;
    logic             w_sel_c1;
    logic             w_sel_c2;
    logic [1:0]       w_status_clr;
    logic [31:0]      w_rdata;

    logic [1:0]       r_status;
    logic [1:0]       r_ctrl;
    logic [CNT_W-1:0] r_count1;
    logic [CNT_W-1:0] r_count2;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn_n (btn1),
        .o_level (w_level[0]),
        .o_press (w_press[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn_n (btn2),
        .o_level (w_level[1]),
        .o_press (w_press[1])
    );

    // A write strobe always wins; a simultaneous read is dropped entirely.
    assign w_rd         = read_enable & ~write_enable;
    assign w_sel_status = (address == ADDR_WIDTH'(ADDR_STATUS));
    assign w_sel_ctrl   = (address == ADDR_WIDTH'(ADDR_CTRL));
    assign w_sel_c1     = (address == ADDR_WIDTH'(ADDR_COUNT1));
    assign w_sel_c2     = (address == ADDR_WIDTH'(ADDR_COUNT2));

    always_comb begin
        w_status_clr = 2'b00;
        if (w_rd && w_sel_status) begin
            w_status_clr = 2'b11;
        end else if (write_enable && w_sel_status) begin
            w_status_clr = data_in[1:0];
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_status) begin
            w_rdata[1:0] = r_status;
        end else if (address == ADDR_WIDTH'(ADDR_LEVEL)) begin
            w_rdata[1:0] = w_level;
        end else if (w_sel_ctrl) begin
            w_rdata[1:0] = r_ctrl;
        end else if (w_sel_c1) begin
            w_rdata[CNT_W-1:0] = r_count1;
        end else if (w_sel_c2) begin
            w_rdata[CNT_W-1:0] = r_count2;
        end
    end

    // Press events OR in after the clear so a coincident event is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_status <= 2'b00;
            r_ctrl   <= 2'b00;
            r_count1 <= '0;
            r_count2 <= '0;
            data_out <= '0;
            irq      <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_status_clr) | w_press;
            if (write_enable && w_sel_ctrl) begin
                r_ctrl <= data_in[1:0];
            end
            r_count1 <= (write_enable && w_sel_c1) ? CNT_W'(w_press[0]) : r_count1 + CNT_W'(w_press[0]);
            r_count2 <= (write_enable && w_sel_c2) ? CNT_W'(w_press[1]) : r_count2 + CNT_W'(w_press[1]);
            data_out <= w_rd ? w_rdata : 32'h0;
            irq      <= |(r_status & r_ctrl);
        end
    end

endmodule
